// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - dot-product operand sequencer driving an external MAC
module mac_dot_seq #(
  parameter int DW    = 8,
  parameter int ACCW  = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  input  logic [AW:0]     len,
  input  logic [ACCW-1:0] mac_out,
  output logic [DW-1:0]   mac_opa,
  output logic [DW-1:0]   mac_opb,
  output logic            mac_clr,
  output logic            busy,
  output logic [ACCW-1:0] result,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        state;
  logic [DW-1:0] bank_a [DEPTH];
  logic [DW-1:0] bank_b [DEPTH];
  logic [AW-1:0] idx;
  logic [AW:0]   len_q;
  logic [AW-1:0] idx_nxt;
  logic          last_pair;

  assign idx_nxt   = idx + 1'b1;
  assign last_pair = ({1'b0, idx} == (len_q - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      len_q   <= '0;
      mac_opa <= '0;
      mac_opb <= '0;
      mac_clr <= 1'b1;
      busy    <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // Banks are only writable here, so a run always sees a frozen snapshot
          if (wr_en) begin
            if (wr_sel) bank_b[wr_addr] <= wr_data;
            else        bank_a[wr_addr] <= wr_data;
          end
          if (start) begin
            if (len == '0 || len > DEPTH_L) begin
              err <= 1'b1;
            end else begin
              len_q   <= len;
              idx     <= '0;
              mac_opa <= bank_a[0];
              mac_opb <= bank_b[0];
              mac_clr <= 1'b0;
              busy    <= 1'b1;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (last_pair) begin
            mac_opa <= '0;
            mac_opb <= '0;
            state   <= CAPTURE;
          end else begin
            idx     <= idx_nxt;
            mac_opa <= bank_a[idx_nxt];
            mac_opb <= bank_b[idx_nxt];
          end
        end
        CAPTURE: begin
          // The MAC has absorbed the final pair; clr goes high so the next run starts at 0
          result  <= mac_out;
          done    <= 1'b1;
          busy    <= 1'b0;
          mac_clr <= 1'b1;
          idx     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb/tb_mac_dot_seq.sv - self-checking bench for mac_dot_seq with a behavioural MAC
module tb_mac_dot_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        start = 1'b0;
  logic [4:0]  len = '0;
  logic [15:0] mac_out;
  logic [7:0]  mac_opa, mac_opb;
  logic        mac_clr, busy, done, err;
  logic [15:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_cmp  = 1'b0;

  mac_dot_seq dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .len(len), .mac_out(mac_out),
    .mac_opa(mac_opa), .mac_opb(mac_opb), .mac_clr(mac_clr), .busy(busy),
    .result(result), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Downstream MAC as described by its contract
  initial mac_out = '0;
  always @(posedge clk) begin
    if (mac_clr) mac_out <= '0;
    else         mac_out <= mac_out + mac_opa * mac_opb;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bank images plus a countdown of edges until done
  logic [7:0]  ma [16];
  logic [7:0]  mb [16];
  int          m_rem, m_len;
  bit          m_busy, m_done, m_err;
  logic [15:0] m_result, m_pending;

  function automatic logic [15:0] dot(input int n);
    int s = 0;
    logic [15:0] r;
    for (int k = 0; k < n; k++) s += int'(ma[k]) * int'(mb[k]);
    r = s[15:0];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_len = 0; m_busy = 0; m_done = 0; m_err = 0; m_result = '0; m_pending = '0;
      for (int k = 0; k < 16; k++) begin ma[k] = '0; mb[k] = '0; end
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1; m_result = m_pending;
        end
      end else begin
        if (start) begin
          if (len == 0 || len > 16) m_err = 1;
          else begin
            m_len = int'(len); m_rem = m_len + 1; m_busy = 1; m_pending = dot(m_len);
          end
        end
        if (wr_en) begin
          if (wr_sel) mb[wr_addr] = wr_data;
          else        ma[wr_addr] = wr_data;
        end
      end
    end
  end

  function automatic logic [7:0] exp_op(input bit sel_b);
    int p;
    if (!m_busy) return '0;
    p = m_len + 1 - m_rem;
    if (p >= m_len) return '0;
    return sel_b ? mb[p] : ma[p];
  endfunction

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("busy",    32'(busy),    32'(m_busy));
      chk("done",    32'(done),    32'(m_done));
      chk("err",     32'(err),     32'(m_err));
      chk("mac_clr", 32'(mac_clr), 32'(!m_busy));
      chk("result",  32'(result),  32'(m_result));
      chk("mac_opa", 32'(mac_opa), 32'(exp_op(1'b0)));
      chk("mac_opb", 32'(mac_opb), 32'(exp_op(1'b1)));
    end
  end

  task automatic wr(input bit sel, input int addr, input int data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr[3:0]; wr_data = data[7:0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Waits for done; returns edges from the start edge to the done edge and busy cycles seen
  task automatic wait_done(output int lat, output int busy_cyc);
    int edges = 0;
    busy_cyc = 0;
    lat = -1;
    while (edges < 40) begin
      @(negedge clk);
      edges++;
      if (start) start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin lat = edges - 1; break; end
    end
    if (lat < 0) chk("done_timeout", 32'(edges), 32'(0));
  endtask

  task automatic run(input int n, output int lat, output int busy_cyc);
    start = 1'b1; len = n[4:0];
    wait_done(lat, busy_cyc);
  endtask

  int lat, bcyc;

  initial begin
    repeat (3) @(negedge clk);
    run_cmp = 1'b1;
    chk("rst_clr", 32'(mac_clr), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_clr", 32'(mac_clr), 32'd1);
    chk("idle_opa", 32'(mac_opa), 32'd0);

    for (int i = 0; i < 10; i++) begin wr(0, i, i + 1); wr(1, i, 10); end
    run(10, lat, bcyc);
    chk("t1_result", 32'(result), 32'd550);
    chk("t1_latency", 32'(lat), 32'd11);
    chk("t1_busy_cycles", 32'(bcyc), 32'd11);
    chk("t1_clr_after", 32'(mac_clr), 32'd1);

    wr(0, 0, 255); wr(0, 1, 255); wr(1, 0, 255); wr(1, 1, 255);
    run(2, lat, bcyc);
    chk("t2_result", 32'(result), 32'd64514);
    chk("t2_latency", 32'(lat), 32'd3);

    for (int j = 0; j < 2; j++) begin
      start = 1'b1; len = (j == 0) ? 5'd0 : 5'd17;
      @(negedge clk);
      start = 1'b0;
      chk("bad_len_err", 32'(err), 32'd1);
      chk("bad_len_busy", 32'(busy), 32'd0);
      chk("bad_len_clr", 32'(mac_clr), 32'd1);
      @(negedge clk);
      chk("bad_len_err_pulse", 32'(err), 32'd0);
      chk("bad_len_result", 32'(result), 32'd64514);
    end

    // len=4 run with a bank write and a restart attempted mid-run; 255*255*2 + 3*10 + 4*10 mod 2^16
    start = 1'b1; len = 5'd4;
    @(negedge clk);
    start = 1'b1; len = 5'd1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd0;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_done(lat, bcyc);
    chk("t4_result", 32'(result), 32'd64584);
    start = 1'b1; len = 5'd4;
    wait_done(lat, bcyc);
    chk("t4_b2b_result", 32'(result), 32'd64584);
    chk("t4_b2b_latency", 32'(lat), 32'd5);

    start = 1'b1; len = 5'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_clr", 32'(mac_clr), 32'd1);
    chk("arst_opa", 32'(mac_opa), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    wr(0, 0, 3); wr(1, 0, 4);
    run(1, lat, bcyc);
    chk("t5_result", 32'(result), 32'd12);
    chk("t5_latency", 32'(lat), 32'd2);
    repeat (2) @(negedge clk);
    run_cmp = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
